alu_md: RTL and testbench

- Parametrised, sequential successor to the single-cycle integer ALU.
- Adds operand width as a parameter, a valid/ready handshake on both sides, and iterative RV32M multiply/divide/remainder.
- Sits in the execute stage. The core stalls on in_ready/out_valid instead of assuming a single-cycle result.
- Base ops complete in 1 cycle; MUL*/DIV*/REM* take WIDTH+1 cycles.

---
 rtl/alu_md.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_alu_md.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
//==============================================================================
// Module      : alu_md
// Description : Sequential integer ALU for the execute stage. It has a
//               valid/ready handshake on the input and output sides. Base ops
//               finish in one cycle. RV32M multiply/divide/remainder ops use
//               an iterative radix-2 datapath (shift-add multiply and
//               restoring divide) and take WIDTH+1 cycles.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               in_valid   - operation offered
//               in_ready   - block can accept (state is IDLE)
//               op[4:0]    - operation select
//               src_a/b    - operands, WIDTH bits
//               out_valid  - result valid, held until out_ready
//               out_ready  - consumer takes the result
//               result     - registered result
//               zero       - registered (result == 0)
//               flush      - abort in BUSY/DONE; present only when
//                            ALU_MD_FLUSH_EN is defined
// Options     : `define ALU_MD_FLUSH_EN adds the flush port
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
`ifdef ALU_MD_FLUSH_EN
    output logic             zero,
    input  logic             flush
`else
    output logic             zero
`endif
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             fix_q, fix_d;      // iterations finished, fix-up cycle next
    logic [2:0]       mop_q, mop_d;      // captured M-op code
    logic             neg_q, neg_d;      // result needs negation
    logic [WIDTH-1:0] dvs_q, dvs_d;      // multiplicand or divisor
    logic [WIDTH-1:0] acc_q, acc_d;      // product high half or partial remainder
    logic [WIDTH-1:0] mq_q, mq_d;        // multiplier/product low half or dividend/quotient
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             res_we;
    logic             flush_w;

`ifdef ALU_MD_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;

    // ---------------------------------------------------------------- base ops
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] base_res;

    assign shamt = src_b[SHW-1:0];

    always_comb begin
        base_res = '0;
        case (op[3:0])
            4'b0000: base_res = src_a + src_b;
            4'b1000: base_res = src_a - src_b;
            4'b0111: base_res = src_a & src_b;
            4'b0110: base_res = src_a | src_b;
            4'b0100: base_res = src_a ^ src_b;
            4'b0010: base_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'b0011: base_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            4'b0001: base_res = src_a << shamt;
            4'b0101: base_res = src_a >> shamt;
            4'b1101: base_res = WIDTH'($signed(src_a) >>> shamt);
            4'b1111: base_res = src_b;
            default: base_res = '0;
        endcase
    end

    // ------------------------------------------------------ operand magnitudes
    logic             a_sgn, b_sgn;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             b_is_zero, div_ovf;

    assign a_sgn     = src_a[WIDTH-1];
    assign b_sgn     = src_b[WIDTH-1];
    // The most-negative value maps onto itself, which read unsigned is its magnitude.
    assign a_mag     = a_sgn ? (~src_a + WIDTH'(1)) : src_a;
    assign b_mag     = b_sgn ? (~src_b + WIDTH'(1)) : src_b;
    assign b_is_zero = (src_b == '0);
    assign div_ovf   = (src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (src_b == '1);

    // ------------------------------------------------------- iteration datapath
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;

    // Multiply: conditionally add the multiplicand to the high half, then shift
    // the 2*WIDTH product right by one, retiring one multiplier bit.
    assign mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});

    // Restoring divide: shift the next dividend bit into the partial remainder.
    // When the subtraction succeeds the difference is below the divisor, so
    // the low WIDTH bits of the subtraction are exact.
    assign div_sh  = {acc_q, mq_q[WIDTH-1]};
    assign div_ge  = (div_sh >= {1'b0, dvs_q});
    assign div_sub = div_sh[WIDTH-1:0] - dvs_q;

    // ----------------------------------------------------------- sign fix-up
    logic [WIDTH-1:0] hi_fix, fix_res;

    // High half of the negated 2*WIDTH product: ~hi plus the carry out of the
    // low half, which only occurs when the low half is zero.
    assign hi_fix = neg_q ? (~acc_q + WIDTH'(mq_q == '0)) : acc_q;

    always_comb begin
        fix_res = '0;
        case (mop_q)
            3'b000:                 fix_res = mq_q;
            3'b001, 3'b010, 3'b011: fix_res = hi_fix;
            3'b100, 3'b101:         fix_res = neg_q ? (~mq_q + WIDTH'(1)) : mq_q;
            default:                fix_res = neg_q ? (~acc_q + WIDTH'(1)) : acc_q;
        endcase
    end

    // --------------------------------------------------------- next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fix_d    = fix_q;
        mop_d    = mop_q;
        neg_d    = neg_q;
        dvs_d    = dvs_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        result_d = result_q;
        res_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!flush_w && in_valid) begin
                    if (!op[4]) begin
                        result_d = base_res;
                        res_we   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        mop_d   = op[2:0];
                        cnt_d   = SHW'(WIDTH-1);
                        fix_d   = 1'b0;
                        acc_d   = '0;
                        neg_d   = 1'b0;
                        state_d = ST_BUSY;
                        case (op[2:0])
                            3'b000: begin           // low half is sign-agnostic
                                dvs_d = src_a;
                                mq_d  = src_b;
                            end
                            3'b001: begin
                                dvs_d = a_mag;
                                mq_d  = b_mag;
                                neg_d = a_sgn ^ b_sgn;
                            end
                            3'b010: begin
                                dvs_d = a_mag;
                                mq_d  = src_b;
                                neg_d = a_sgn;
                            end
                            3'b011: begin
                                dvs_d = src_a;
                                mq_d  = src_b;
                            end
                            3'b100, 3'b110: begin   // DIV / REM
                                dvs_d = b_mag;
                                mq_d  = a_mag;
                                neg_d = op[1] ? a_sgn : (a_sgn ^ b_sgn);
                                if (b_is_zero) begin
                                    result_d = op[1] ? src_a : '1;
                                    res_we   = 1'b1;
                                    state_d  = ST_DONE;
                                end else if (div_ovf) begin
                                    result_d = op[1] ? '0 : src_a;
                                    res_we   = 1'b1;
                                    state_d  = ST_DONE;
                                end
                            end
                            default: begin          // DIVU / REMU
                                dvs_d = src_b;
                                mq_d  = src_a;
                                if (b_is_zero) begin
                                    result_d = op[1] ? src_a : '1;
                                    res_we   = 1'b1;
                                    state_d  = ST_DONE;
                                end
                            end
                        endcase
                    end
                end
            end

            ST_BUSY: begin
                if (flush_w) begin
                    state_d = ST_IDLE;
                end else if (fix_q) begin
                    result_d = fix_res;
                    res_we   = 1'b1;
                    fix_d    = 1'b0;
                    state_d  = ST_DONE;
                end else begin
                    if (mop_q[2]) begin
                        acc_d = div_ge ? div_sub : div_sh[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_d = mul_sum[WIDTH:1];
                        mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
                    end
                    if (cnt_q == '0) begin
                        fix_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - SHW'(1);
                    end
                end
            end

            ST_DONE: begin
                if (flush_w || out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        zero_d = res_we ? (result_d == '0) : zero_q;
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            fix_q    <= 1'b0;
            mop_q    <= '0;
            neg_q    <= 1'b0;
            dvs_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fix_q    <= fix_d;
            mop_q    <= mop_d;
            neg_q    <= neg_d;
            dvs_q    <= dvs_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_md.sv
//==============================================================================
// Module      : tb_alu_md
// Description : Directed self-checking bench for alu_md (WIDTH=32) with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_md;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
`ifdef ALU_MD_FLUSH_EN
    logic             flush;
`endif

    int n_total;
    int n_bad;

    alu_md #(.WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
`ifdef ALU_MD_FLUSH_EN
        .zero      (zero),
        .flush     (flush)
`else
        .zero      (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Offer one op, wait for the result, check latency/result/zero, leave it
    // held in DONE (out_ready low) for the caller to release.
    task automatic issue(input string tag, input logic [4:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat);
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        @(posedge clk);                     // acceptance edge
        #1;
        in_valid = 1'b0;
        src_a    = 32'hDEAD_BEEF;           // later input changes must be ignored
        src_b    = 32'h0000_0003;
        op       = 5'b0_0000;
        chk({tag, ".in_ready_low"}, {31'd0, in_ready}, 32'd0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 100);
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".result"}, result, exp_res);
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".out_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".in_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input int exp_lat);
        issue(tag, o, a, b, exp_res, exp_lat);
        release_out(tag);
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 5'd0;
        src_a     = '0;
        src_b     = '0;
`ifdef ALU_MD_FLUSH_EN
        flush     = 1'b0;
`endif
        #1;
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.zero", {31'd0, zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Base ops: one-cycle latency
        run("add",   5'b0_0000, 32'd5,          32'd7,          32'd12,          1);
        run("sub",   5'b0_1000, 32'd3,          32'd3,          32'd0,           1);
        run("sra",   5'b0_1101, 32'h8000_0000,  32'h0000_0024,  32'hF800_0000,   1);
        run("srl",   5'b0_0101, 32'h8000_0000,  32'h0000_0004,  32'h0800_0000,   1);
        run("sll",   5'b0_0001, 32'h0000_0001,  32'h0000_003F,  32'h8000_0000,   1);
        run("slt",   5'b0_0010, 32'hFFFF_FFFF,  32'd1,          32'd1,           1);
        run("sltu",  5'b0_0011, 32'hFFFF_FFFF,  32'd1,          32'd0,           1);
        run("and",   5'b0_0111, 32'h0000_00F0,  32'h0000_003C,  32'h0000_0030,   1);
        run("or",    5'b0_0110, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,   1);
        run("xor",   5'b0_0100, 32'h0000_00FF,  32'h0000_000F,  32'h0000_00F0,   1);
        run("pass",  5'b0_1111, 32'h1111_1111,  32'h0000_1234,  32'h0000_1234,   1);
        run("undef", 5'b0_1001, 32'h1111_1111,  32'h0000_1234,  32'd0,           1);

        // Multiply: WIDTH+1 cycles
        run("mulh",   5'b1_0001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run("mul",    5'b1_0000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run("mulhu",  5'b1_0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run("mulhsu", 5'b1_0010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);

        // Divide / remainder
        run("div",     5'b1_0100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run("div_op3", 5'b1_1100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run("rem",     5'b1_0110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run("remu",    5'b1_0111, 32'd100,       32'd7,         32'd2,         33);
        run("divu0",   5'b1_0101, 32'd100,       32'd0,         32'hFFFF_FFFF, 1);
        run("remu0",   5'b1_0111, 32'd100,       32'd0,         32'd100,       1);
        run("divovf",  5'b1_0100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("removf",  5'b1_0110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Back-pressure: result held stable while out_ready stays low
        issue("divu_bp", 5'b1_0101, 32'd100, 32'd7, 32'd14, 33);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp.result", result, 32'd14);
            chk("bp.out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
        end
        release_out("divu_bp");

        // Reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1;
        op       = 5'b1_0000;
        src_a    = 32'd9;
        src_b    = 32'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst.result", result, 32'd0);
        chk("mrst.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            chk("mrst.no_valid", {31'd0, out_valid}, 32'd0);
        end
        run("add_after_rst", 5'b0_0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);

`ifdef ALU_MD_FLUSH_EN
        // Flush during BUSY: back to IDLE, no result produced
        @(negedge clk);
        in_valid = 1'b1;
        op       = 5'b1_0000;
        src_a    = 32'd3;
        src_b    = 32'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush.in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush.result_kept", result, 32'd0);
        repeat (40) begin
            @(posedge clk);
            #1;
            chk("flush.no_valid", {31'd0, out_valid}, 32'd0);
        end
        run("add_after_flush", 5'b0_0000, 32'd20, 32'd22, 32'd42, 1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
